// File: rtl/codec_init_sequencer.sv
// codec_init_sequencer
// Walks a fixed 8-entry codec register table at start-up, issuing one I2C
// write per entry through I2cInterface, retrying failed or timed-out
// transfers, and reporting done/fail to the audio datapath.
//
// Handshake with I2cInterface: i2c_write is a one-cycle request pulse while
// sub_addr/wr_data are stable; the interface acknowledges by dropping
// i2c_ready, and the transfer ends when i2c_ready rises again, with
// i2c_error qualifying the outcome in that same cycle.
module codec_init_sequencer #(
    parameter int START_DELAY  = 1000,
    parameter int GAP_DELAY    = 16,
    parameter int MAX_RETRY    = 3,
    parameter int BUSY_TIMEOUT = 8
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic       i2c_ready,
    input  logic       i2c_error,
    output logic [7:0] sub_addr,
    output logic [7:0] wr_data,
    output logic       i2c_write,
    output logic       busy,
    output logic       done,
    output logic       fail,
    output logic [2:0] reg_index
);

    // One shared down-counter serves the power-up wait, the inter-transfer
    // gap and the busy timeout; it is sized for the largest of the three.
    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        return m;
    endfunction

    localparam int CNT_MAX = max3(START_DELAY, GAP_DELAY, BUSY_TIMEOUT);
    localparam int CW      = ($clog2(CNT_MAX + 1) > 0) ? $clog2(CNT_MAX + 1) : 1;
    localparam int RW      = ($clog2(MAX_RETRY + 1) > 0) ? $clog2(MAX_RETRY + 1) : 1;

    localparam logic [CW-1:0] CNT_START = CW'(START_DELAY);
    localparam logic [CW-1:0] CNT_GAP   = CW'(GAP_DELAY);
    localparam logic [CW-1:0] CNT_BUSY  = CW'(BUSY_TIMEOUT);
    localparam logic [CW-1:0] CNT_ONE   = CW'(1);
    localparam logic [RW-1:0] RETRY_LIM = RW'(MAX_RETRY);
    localparam logic [RW-1:0] RETRY_ONE = RW'(1);

    // Codec configuration table: {sub_addr, wr_data} per entry.
    function automatic logic [15:0] table_entry(input logic [2:0] idx);
        logic [15:0] word;
        case (idx)
            3'd0:    word = 16'h1E00;  // reset codec
            3'd1:    word = 16'h0C00;  // power down control: all on
            3'd2:    word = 16'h0E02;  // digital audio format: I2S
            3'd3:    word = 16'h1000;  // sampling control
            3'd4:    word = 16'h0812;  // analogue path: DAC select, line in
            3'd5:    word = 16'h0A00;  // digital path: no de-emphasis, unmute
            3'd6:    word = 16'h0017;  // left line in volume
            default: word = 16'h1201;  // activate digital interface
        endcase
        return word;
    endfunction

    typedef enum logic [3:0] {
        S_IDLE,
        S_PWRUP,
        S_ISSUE,
        S_WAIT_BUSY,
        S_WAIT_DONE,
        S_OK,
        S_ERR,
        S_GAP,
        S_DONE,
        S_FAIL
    } state_t;

    state_t        state;
    state_t        state_next;
    logic [CW-1:0] cnt;
    logic [CW-1:0] cnt_next;
    logic [RW-1:0] retry;
    logic [RW-1:0] retry_next;
    logic [2:0]    idx_next;
    logic          load_entry;

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state, counter/index updates and status outputs decoded from state.
    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        retry_next = retry;
        idx_next   = reg_index;
        load_entry = 1'b0;
        i2c_write  = 1'b0;
        busy       = 1'b0;
        done       = 1'b0;
        fail       = 1'b0;

        case (state)
            S_IDLE, S_DONE, S_FAIL: begin
                done = (state == S_DONE);
                fail = (state == S_FAIL);
                if (start) begin
                    state_next = S_PWRUP;
                    cnt_next   = CNT_START;
                    idx_next   = 3'd0;
                    retry_next = '0;
                end
            end

            // Counter loaded with START_DELAY and run down to zero, so the
            // first pulse lands START_DELAY+1 cycles after busy rises.
            S_PWRUP: begin
                busy = 1'b1;
                if (cnt == '0) begin
                    state_next = S_ISSUE;
                    load_entry = 1'b1;
                end else begin
                    cnt_next = cnt - CNT_ONE;
                end
            end

            S_ISSUE: begin
                busy       = 1'b1;
                i2c_write  = 1'b1;
                cnt_next   = CNT_BUSY;
                state_next = S_WAIT_BUSY;
            end

            // The interface must acknowledge by dropping ready; a ready that
            // stays high for BUSY_TIMEOUT cycles counts as a failed transfer.
            S_WAIT_BUSY: begin
                busy = 1'b1;
                if (!i2c_ready) begin
                    state_next = S_WAIT_DONE;
                end else if (cnt <= CNT_ONE) begin
                    state_next = S_ERR;
                end else begin
                    cnt_next = cnt - CNT_ONE;
                end
            end

            S_WAIT_DONE: begin
                busy = 1'b1;
                if (i2c_ready) begin
                    state_next = i2c_error ? S_ERR : S_OK;
                end
            end

            S_OK: begin
                busy       = 1'b1;
                retry_next = '0;
                if (reg_index == 3'd7) begin
                    state_next = S_DONE;
                end else begin
                    idx_next   = reg_index + 3'd1;
                    cnt_next   = CNT_GAP;
                    state_next = S_GAP;
                end
            end

            S_ERR: begin
                busy = 1'b1;
                if (retry < RETRY_LIM) begin
                    retry_next = retry + RETRY_ONE;
                    cnt_next   = CNT_GAP;
                    state_next = S_GAP;
                end else begin
                    state_next = S_FAIL;
                end
            end

            // Exactly GAP_DELAY idle cycles (at least one) before the next pulse.
            S_GAP: begin
                busy = 1'b1;
                if (cnt <= CNT_ONE) begin
                    state_next = S_ISSUE;
                    load_entry = 1'b1;
                end else begin
                    cnt_next = cnt - CNT_ONE;
                end
            end

            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    // Datapath registers: counters, entry index and the registered bus word,
    // which is loaded on entry to ISSUE and held until the next load.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt       <= '0;
            retry     <= '0;
            reg_index <= 3'd0;
            sub_addr  <= 8'h00;
            wr_data   <= 8'h00;
        end else begin
            cnt       <= cnt_next;
            retry     <= retry_next;
            reg_index <= idx_next;
            if (load_entry) begin
                {sub_addr, wr_data} <= table_entry(reg_index);
            end
        end
    end

endmodule
